cmac_mul_arb: RTL and testbench

- Shares one int8 `mul_unit` between NUM_REQ requesters using round-robin arbitration.
- Each requester uses a valid/ready operand handshake; results return tagged with the requester ID.
- The multiplier is wrapped in a 2-stage pipeline (operand register, result register) with full backpressure from the response side.
- Sits between the CMAC operand-fetch lanes and the shared reduced-precision multiplier.

---
 rtl/cmac_mul_arb_pkg.sv | 20 ++
 rtl/cmac_rr_arb.sv | 31 +++
 rtl/mul_unit.sv | 22 ++
 rtl/cmac_mul_arb.sv | 82 ++++++++
 tb/tb_cmac_mul_arb.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cmac_mul_arb_pkg.sv
// Shared widths, default sizing and the round-robin index helper for the
// CMAC multiplier-sharing arbiter.
package cmac_mul_arb_pkg;

    localparam int CMAC_MUL_OP_W   = 8;
    localparam int CMAC_MUL_RES_W  = 16;
    localparam int CMAC_NUM_REQ    = 4;
    localparam int CMAC_ID_W       = 2;

    typedef struct packed {
        logic [CMAC_MUL_OP_W-1:0] a;
        logic [CMAC_MUL_OP_W-1:0] b;
    } cmac_mul_ops_t;

    // k-th candidate after the last winner, wrapping at n
    function automatic int cmac_rr_next(input int last, input int k, input int n);
        return (last + k) % n;
    endfunction

endpackage

// File: rtl/cmac_rr_arb.sv
// Combinational round-robin picker: first requester after `last` wins.
module cmac_rr_arb
    import cmac_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = CMAC_NUM_REQ,
    parameter int ID_W    = CMAC_ID_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = cmac_rr_next(int'(last), k, NUM_REQ);
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Reduced-precision int8 multiplier: sign-magnitude with one's-complement
// encoding of negative operands and results.
module mul_unit
    import cmac_mul_arb_pkg::*;
(
    input  logic [CMAC_MUL_OP_W-1:0]  a,
    input  logic [CMAC_MUL_OP_W-1:0]  b,
    output logic [CMAC_MUL_RES_W-1:0] y
);

    logic                      sign;
    logic [CMAC_MUL_OP_W-1:0]  mag_a;
    logic [CMAC_MUL_OP_W-1:0]  mag_b;
    logic [CMAC_MUL_RES_W-1:0] prod;

    assign sign  = a[CMAC_MUL_OP_W-1] ^ b[CMAC_MUL_OP_W-1];
    assign mag_a = a[CMAC_MUL_OP_W-1] ? ~a : a;
    assign mag_b = b[CMAC_MUL_OP_W-1] ? ~b : b;
    assign prod  = CMAC_MUL_RES_W'(mag_a) * CMAC_MUL_RES_W'(mag_b);
    assign y     = sign ? ~prod : prod;

endmodule

// File: rtl/cmac_mul_arb.sv
// Round-robin sharing of one int8 mul_unit across NUM_REQ operand lanes,
// with a 2-stage (operand, result) pipeline under full response backpressure.
module cmac_mul_arb
    import cmac_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = CMAC_NUM_REQ,
    parameter int ID_W    = CMAC_ID_W,
    parameter int CNT_W   = 32
) (
    input  logic                             nvdla_core_clk,
    input  logic                             nvdla_core_rstn,
    input  logic                             mul_en,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*CMAC_MUL_OP_W-1:0] req_a,
    input  logic [NUM_REQ*CMAC_MUL_OP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_W-1:0]                  rsp_id,
    output logic [CMAC_MUL_RES_W-1:0]        rsp_data,
    output logic [CNT_W-1:0]                 op_cnt,
    output logic                             idle
);

    logic                      adv;
    logic                      arb_en;
    logic                      s1_vld;
    logic [ID_W-1:0]           s1_id;
    cmac_mul_ops_t             s1_ops;
    logic [ID_W-1:0]           last;
    logic [ID_W-1:0]           gnt_id;
    logic                      gnt_any;
    logic [CMAC_MUL_RES_W-1:0] mul_out;

    assign adv    = !rsp_valid || rsp_ready;
    // Grants are suppressed in reset so req_ready reads 0 while held
    assign arb_en = adv && mul_en && nvdla_core_rstn;
    assign idle   = !s1_vld && !rsp_valid;

    cmac_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req     (req_valid & {NUM_REQ{arb_en}}),
        .last    (last),
        .gnt     (req_ready),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    mul_unit u_mul (
        .a (s1_ops.a),
        .b (s1_ops.b),
        .y (mul_out)
    );

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            s1_vld    <= 1'b0;
            s1_id     <= '0;
            s1_ops    <= '0;
            last      <= ID_W'(NUM_REQ - 1);
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            op_cnt    <= '0;
        end else begin
            if (adv) begin
                s1_vld <= gnt_any;
                if (gnt_any) begin
                    s1_ops.a <= req_a[CMAC_MUL_OP_W*int'(gnt_id) +: CMAC_MUL_OP_W];
                    s1_ops.b <= req_b[CMAC_MUL_OP_W*int'(gnt_id) +: CMAC_MUL_OP_W];
                    s1_id    <= gnt_id;
                    last     <= gnt_id;
                end
                rsp_valid <= s1_vld;
                rsp_id    <= s1_id;
                rsp_data  <= mul_out;
            end
            if (rsp_valid && rsp_ready)
                op_cnt <= op_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmac_mul_arb.sv
// Randomized and directed check of cmac_mul_arb against a transaction-level
// model of the arbiter, 2-slot pipeline and sign-magnitude multiply.
module tb_cmac_mul_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 32;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 mul_en = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*8-1:0] req_a = '0;
    logic [NUM_REQ*8-1:0] req_b = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_data;
    logic [CNT_W-1:0]     op_cnt;
    logic                 idle;

    int checks = 0;
    int errors = 0;

    cmac_mul_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .mul_en          (mul_en),
        .req_valid       (req_valid),
        .req_a           (req_a),
        .req_b           (req_b),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .op_cnt          (op_cnt),
        .idle            (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sign-magnitude product in plain integer arithmetic
    function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b);
        int ma, mb, p;
        ma = a[7] ? 255 - int'(a) : int'(a);
        mb = b[7] ? 255 - int'(b) : int'(b);
        p  = ma * mb;
        return (a[7] ^ b[7]) ? 16'(65535 - p) : 16'(p);
    endfunction

    // Model: one slot feeding the multiplier, one slot at the output
    bit          m_ok = 0, m_in_rst = 0;
    bit          m_out_v = 0, m_s1_v = 0;
    int          m_out_id = 0, m_s1_id = 0, m_last = NUM_REQ - 1;
    logic [15:0] m_out_d = '0;
    logic [7:0]  m_s1_a = '0, m_s1_b = '0;
    logic [31:0] m_cnt = '0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] eg;
        int gi, i;
        bit adv;
        adv = !m_out_v || rsp_ready;
        eg  = '0;
        gi  = -1;
        if (rstn && adv && mul_en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                i = (m_last + k) % NUM_REQ;
                if (gi < 0 && req_valid[i]) begin
                    gi    = i;
                    eg[i] = 1'b1;
                end
            end
        end
        if (m_ok) begin
            chk("m_req_ready", 64'(req_ready), 64'(eg));
            chk("m_rsp_valid", 64'(rsp_valid), 64'(m_out_v));
            chk("m_idle", 64'(idle), 64'(!m_s1_v && !m_out_v));
            chk("m_op_cnt", 64'(op_cnt), 64'(m_cnt));
            if (m_out_v || m_in_rst) begin
                chk("m_rsp_id", 64'(rsp_id), 64'(m_out_id));
                chk("m_rsp_data", 64'(rsp_data), 64'(m_out_d));
            end
        end
        if (!rstn) begin
            m_ok = 1; m_in_rst = 1;
            m_out_v = 0; m_s1_v = 0; m_out_id = 0; m_s1_id = 0;
            m_out_d = '0; m_s1_a = '0; m_s1_b = '0; m_cnt = '0;
            m_last = NUM_REQ - 1;
        end else begin
            m_in_rst = 0;
            if (m_out_v && rsp_ready) m_cnt = m_cnt + 1;
            if (adv) begin
                m_out_v  = m_s1_v;
                m_out_id = m_s1_id;
                m_out_d  = golden(m_s1_a, m_s1_b);
                m_s1_v   = (gi >= 0);
                if (gi >= 0) begin
                    m_s1_id = gi;
                    m_s1_a  = req_a[8*gi +: 8];
                    m_s1_b  = req_b[8*gi +: 8];
                    m_last  = gi;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [ID_W-1:0] sv_id;
        logic [15:0]     sv_d;
        bit              found;

        repeat (3) tick;
        rstn = 1'b1;

        // Single op from requester 0
        req_valid = 4'b0001; req_a[7:0] = 8'h03; req_b[7:0] = 8'h05;
        @(negedge clk); chk("single_gnt", 64'(req_ready), 64'h1);
        tick; req_valid = '0;
        tick;
        @(negedge clk);
        chk("single_vld", 64'(rsp_valid), 64'h1);
        chk("single_id", 64'(rsp_id), 64'h0);
        chk("single_data", 64'(rsp_data), 64'd15);
        tick;
        @(negedge clk); chk("single_cnt", 64'(op_cnt), 64'h1);

        // Round robin from a fresh reset
        rstn = 1'b0; tick; tick;
        rstn = 1'b1; req_a = $urandom; req_b = $urandom; req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 6) chk("rr_gnt", 64'(req_ready), 64'(4'b0001 << (c % 4)));
            if (c >= 2) begin
                chk("rr_vld", 64'(rsp_valid), 64'h1);
                chk("rr_id", 64'((c - 2) % 4), 64'(rsp_id));
            end
            tick;
        end
        req_valid = '0;
        repeat (3) tick;

        // Backpressure on a requester-2 stream
        req_valid = 4'b0100;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            req_a[23:16] = 8'($urandom); req_b[23:16] = 8'($urandom);
            tick;
            if (rsp_valid) begin found = 1; break; end
        end
        chk("bp_rise", 64'(found), 64'h1);
        rsp_ready = 1'b0; sv_id = rsp_id; sv_d = rsp_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_gnt", 64'(req_ready), 64'h0);
            chk("bp_vld", 64'(rsp_valid), 64'h1);
            chk("bp_id", 64'(rsp_id), 64'd2);
            chk("bp_data", 64'(rsp_data), 64'(sv_d));
            chk("bp_id_hold", 64'(rsp_id), 64'(sv_id));
            req_a[23:16] = 8'($urandom);
            tick;
        end
        rsp_ready = 1'b1;
        repeat (3) tick;
        req_valid = '0;
        repeat (4) tick;

        // Negative operand takes the one's-complement branch
        req_valid = 4'b0001; req_a[7:0] = 8'hFE; req_b[7:0] = 8'h05;
        tick; req_valid = '0;
        tick;
        @(negedge clk);
        chk("neg_vld", 64'(rsp_valid), 64'h1);
        chk("neg_data", 64'(rsp_data), 64'hFFFA);
        repeat (2) tick;

        // mul_en drop with two ops in flight
        req_valid = 4'hF;
        tick; tick;
        mul_en = 1'b0;
        @(negedge clk);
        chk("en_gnt", 64'(req_ready), 64'h0);
        chk("en_rsp0", 64'(rsp_valid), 64'h1);
        tick;
        @(negedge clk); chk("en_rsp1", 64'(rsp_valid), 64'h1);
        tick;
        @(negedge clk);
        chk("en_idle", 64'(idle), 64'h1);
        chk("en_vld", 64'(rsp_valid), 64'h0);
        mul_en = 1'b1; req_valid = '0;
        tick;

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            req_valid = NUM_REQ'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            if ($urandom_range(0, 7) == 0) req_a[7:0] = 8'h80;
            if ($urandom_range(0, 7) == 0) req_b[15:8] = 8'hFF;
            rsp_ready = ($urandom_range(0, 3) != 0);
            mul_en    = ($urandom_range(0, 7) != 0);
            tick;
        end

        // Reset with both stages occupied
        mul_en = 1'b1; rsp_ready = 1'b1; req_valid = '0;
        repeat (3) tick;
        req_valid = 4'hF;
        tick; tick;
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_vld", 64'(rsp_valid), 64'h0);
        chk("rst_cnt", 64'(op_cnt), 64'h0);
        chk("rst_idle", 64'(idle), 64'h1);
        chk("rst_gnt", 64'(req_ready), 64'h1);
        tick; tick;
        req_valid = '0;
        repeat (4) tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
